// File: rtl/iq_fir_scheduler.sv
// iq_fir_scheduler: one shared pre-add/MAC engine time-multiplexed between the I and Q
// streams of a symmetric 8-tap low-pass FIR, with round-robin grant and valid/ready output.
module iq_fir_scheduler #(
  parameter int DATA_W = 5,
  parameter int COEF_W = 8,
  parameter logic signed [COEF_W-1:0] C0 = COEF_W'(-11),
  parameter logic signed [COEF_W-1:0] C1 = COEF_W'(2),
  parameter logic signed [COEF_W-1:0] C2 = COEF_W'(26),
  parameter logic signed [COEF_W-1:0] C3 = COEF_W'(48),
  parameter int FRAC = 7
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic signed [DATA_W-1:0] q_data,
  input  logic                     q_valid,
  output logic                     q_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     out_chan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int AW = DATA_W + COEF_W + 3;
  localparam int PW = DATA_W + 1 + COEF_W;
  localparam logic signed [AW-1:0] SMAX = AW'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(1 <<< (DATA_W - 1)));

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t state;
  logic [1:0] k;
  logic chan, last_q;
  logic signed [DATA_W-1:0] line_i [8];
  logic signed [DATA_W-1:0] line_q [8];
  logic signed [AW-1:0] acc, acc_next, shifted;
  logic signed [DATA_W:0] pre;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] tap_a, tap_b, result;
  logic grant_i, grant_q, slot_free, load;

  // tap 7-k is {1,~k}, so each step pairs a tap with its mirror
  always_comb begin
    grant_i   = i_valid && (!q_valid || last_q);
    grant_q   = q_valid && (!i_valid || !last_q);
    i_ready   = resetn && state == IDLE && grant_i;
    q_ready   = resetn && state == IDLE && grant_q;
    tap_a     = chan ? line_q[{1'b0, k}] : line_i[{1'b0, k}];
    tap_b     = chan ? line_q[{1'b1, ~k}] : line_i[{1'b1, ~k}];
    coef      = k == 2'd0 ? C0 : k == 2'd1 ? C1 : k == 2'd2 ? C2 : C3;
    pre       = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
    acc_next  = acc + AW'(PW'(pre) * PW'(coef));
    shifted   = (state == HOLD ? acc : acc_next) >>> FRAC;
    result    = shifted > SMAX ? DATA_W'(SMAX) : shifted < SMIN ? DATA_W'(SMIN) : shifted[DATA_W-1:0];
    slot_free = !out_valid || out_ready;
    load      = slot_free && (state == HOLD || (state == MAC && k == 2'd3));
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      k         <= 2'd0;
      chan      <= 1'b0;
      last_q    <= 1'b1;
      acc       <= '0;
      data_out  <= '0;
      out_chan  <= 1'b0;
      out_valid <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        line_i[j] <= '0;
        line_q[j] <= '0;
      end
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (load) begin
        data_out  <= result;
        out_chan  <= chan;
        out_valid <= 1'b1;
      end
      case (state)
        IDLE: if (i_ready || q_ready) begin
          if (q_ready) begin
            line_q[0] <= q_data;
            for (int j = 7; j > 0; j--) line_q[j] <= line_q[j-1];
          end else begin
            line_i[0] <= i_data;
            for (int j = 7; j > 0; j--) line_i[j] <= line_i[j-1];
          end
          chan   <= q_ready;
          last_q <= q_ready;
          acc    <= '0;
          k      <= 2'd0;
          state  <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 2'd1;
          if (k == 2'd3) state <= load ? IDLE : HOLD;
        end
        HOLD: if (load) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iq_fir_scheduler.sv
// tb_iq_fir_scheduler: directed and randomized checks of iq_fir_scheduler against a
// direct-form FIR model with a result queue per accepted sample.
module tb_iq_fir_scheduler;
  logic clk = 0, resetn = 1;
  logic signed [4:0] i_data = 0, q_data = 0, data_out;
  logic i_valid = 0, q_valid = 0, i_ready, q_ready, out_chan, out_valid, out_ready = 1, busy;

  typedef struct {bit ch; int v; int t;} exp_t;
  localparam int H[8] = '{-11, 2, 26, 48, 48, 26, 2, -11};

  int tests = 0, fails = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int out_log[$];
  int chan_log[$];
  int li[8], lq[8], tmpl[8], pin[8];
  bit last_ch = 1, free_mode = 0, head_seen = 0, prev_stall = 0, mon_ch;
  int seen_cyc = 0, last_acc = -100, prev_data = 0, prev_chan = 0;

  iq_fir_scheduler dut (
    .clk(clk), .resetn(resetn),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .data_out(data_out), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int fir(input int l[8]);
    int s = 0;
    for (int j = 0; j < 8; j++) s += H[j] * l[j];
    s = s >>> 7;
    return s > 15 ? 15 : s < -16 ? -16 : s;
  endfunction

  // scoreboard: every accepted sample predicts one tagged result, in order
  always @(negedge clk) if (resetn) begin
    if (prev_stall) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(data_out), prev_data);
      chk("hold_chan", int'(out_chan), prev_chan);
    end
    prev_stall = out_valid && !out_ready;
    prev_data = int'(data_out);
    prev_chan = int'(out_chan);
    if (out_valid && !head_seen) begin
      head_seen = 1;
      seen_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_chan", int'(out_chan), int'(mon_e.ch));
        chk("out_data", int'(data_out), mon_e.v);
        if (free_mode) chk("latency", seen_cyc - mon_e.t, 5);
        out_log.push_back(int'(data_out));
        chan_log.push_back(int'(out_chan));
      end
      head_seen = 0;
    end
    chk("one_ready", int'(i_ready && q_ready), 0);
    chk("ready_needs_valid", int'((i_ready && !i_valid) || (q_ready && !q_valid)), 0);
    if (cyc <= last_acc + 4) begin
      chk("busy_mac", int'(busy), 1);
      chk("ready_in_mac", int'(i_ready || q_ready), 0);
    end else if (free_mode) chk("ready_free", int'(i_ready || q_ready), int'(i_valid || q_valid));
    if (i_ready || q_ready) chk("busy_idle", int'(busy), 0);
    if ((i_valid && i_ready) || (q_valid && q_ready)) begin
      mon_ch = q_valid && q_ready;
      chk("grant", int'(mon_ch), (i_valid && q_valid) ? int'(!last_ch) : int'(q_valid));
      if (mon_ch) begin
        for (int j = 7; j > 0; j--) lq[j] = lq[j-1];
        lq[0] = int'(q_data);
        tmpl = lq;
      end else begin
        for (int j = 7; j > 0; j--) li[j] = li[j-1];
        li[0] = int'(i_data);
        tmpl = li;
      end
      exp_q.push_back('{mon_ch, fir(tmpl), cyc});
      last_ch = mon_ch;
      last_acc = cyc;
    end
  end

  task automatic do_reset();
    i_valid = 1;
    q_valid = 1;
    resetn = 0;
    @(negedge clk);
    chk("rst_i_ready", int'(i_ready), 0);
    chk("rst_q_ready", int'(q_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    @(posedge clk); #1;
    i_valid = 0;
    q_valid = 0;
    for (int j = 0; j < 8; j++) begin
      li[j] = 0;
      lq[j] = 0;
    end
    exp_q.delete();
    out_log.delete();
    chan_log.delete();
    last_ch = 1;
    head_seen = 0;
    prev_stall = 0;
    last_acc = -100;
    resetn = 1;
  endtask

  task automatic put(input bit ch, input int v);
    int n = 0;
    bit hs;
    if (ch) begin q_data = 5'(v); q_valid = 1; end
    else begin i_data = 5'(v); i_valid = 1; end
    do begin
      @(negedge clk);
      n++;
      hs = ch ? (q_valid && q_ready) : (i_valid && i_ready);
    end while (!hs && n < 100);
    if (!hs) chk("put_timeout", 0, 1);
    @(posedge clk); #1;
    if (ch) q_valid = 0; else i_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  task automatic impulse_test();
    int exp_imp[8] = '{-2, 0, 3, 5, 5, 3, 0, -2};
    put(0, 15);
    repeat (7) put(0, 0);
    drain();
    chk("imp_count", out_log.size(), 8);
    for (int j = 0; j < 8 && j < out_log.size(); j++) begin
      chk("imp_value", out_log[j], exp_imp[j]);
      chk("imp_chan", chan_log[j], 0);
    end
  endtask

  initial begin
    bit hi, hq;
    #2;
    pin = '{15, 0, 0, 0, 0, 0, 0, 0};
    chk("model_impulse", fir(pin), -2);
    pin = '{0, 0, 0, 15, 0, 0, 0, 0};
    chk("model_tap3", fir(pin), 5);
    pin = '{15, 15, 15, 15, 15, 15, 15, 15};
    chk("model_dc_pos", fir(pin), 15);
    pin = '{-16, -16, -16, -16, -16, -16, -16, -16};
    chk("model_dc_neg", fir(pin), -16);
    pin = '{-16, 15, 15, 15, 15, 15, 15, -16};
    chk("model_sat", fir(pin), 15);

    do_reset();
    free_mode = 1;
    impulse_test();

    do_reset();
    repeat (8) put(0, 15);
    drain();
    chk("dc_i_count", out_log.size(), 8);
    chk("dc_i", out_log[7], 15);
    repeat (8) put(1, -16);
    drain();
    chk("dc_q_count", out_log.size(), 16);
    chk("dc_q", out_log[15], -16);
    chk("dc_q_chan", chan_log[15], 1);

    do_reset();
    put(0, -16);
    repeat (6) put(0, 15);
    put(0, -16);
    drain();
    chk("sat_value", out_log[7], 15);

    do_reset();
    i_valid = 1;
    q_valid = 1;
    i_data = 5'($urandom);
    q_data = 5'($urandom);
    repeat (200) begin
      @(negedge clk);
      hi = i_valid && i_ready;
      hq = q_valid && q_ready;
      @(posedge clk); #1;
      if (hi) i_data = 5'($urandom);
      if (hq) q_data = 5'($urandom);
    end
    i_valid = 0;
    q_valid = 0;
    drain();
    chk("arb_count_min", int'(out_log.size() >= 38), 1);
    for (int j = 0; j < chan_log.size(); j++) chk("arb_alternate", chan_log[j], j % 2);

    do_reset();
    free_mode = 0;
    out_ready = 0;
    put(0, 15);
    put(0, 0);
    repeat (10) begin @(posedge clk); #1; end
    i_valid = 1;
    q_valid = 1;
    @(negedge clk);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_first", int'(data_out), -2);
    chk("bp_busy", int'(busy), 1);
    chk("bp_i_ready", int'(i_ready), 0);
    chk("bp_q_ready", int'(q_ready), 0);
    @(posedge clk); #1;
    i_valid = 0;
    q_valid = 0;
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second_valid", int'(out_valid), 1);
    chk("bp_second", int'(data_out), 0);
    @(posedge clk); #1;
    drain();

    do_reset();
    free_mode = 1;
    put(0, 15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    repeat (8) begin
      @(negedge clk);
      chk("rst_abort", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    impulse_test();

    do_reset();
    free_mode = 0;
    repeat (3000) begin
      @(negedge clk);
      hi = i_valid && i_ready;
      hq = q_valid && q_ready;
      @(posedge clk); #1;
      if (!i_valid || hi) begin i_valid = 1'($urandom_range(0, 1)); i_data = 5'($urandom); end
      if (!q_valid || hq) begin q_valid = 1'($urandom_range(0, 1)); q_data = 5'($urandom); end
      out_ready = $urandom_range(0, 3) != 0;
    end
    i_valid = 0;
    q_valid = 0;
    out_ready = 1;
    drain();
    chk("rand_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
